abs_diff_seq_ctrl: RTL and testbench

ABS_DIFF_SEQ_CTRL -- requirements
Module: abs_diff_seq_ctrl

---
 rtl/abs_diff_pkg.sv | 20 ++
 rtl/digit_add_slice.sv | 14 +
 rtl/abs_diff_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_abs_diff_seq_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/abs_diff_pkg.sv
// Shared definitions for the digit-serial absolute-difference engine.
package abs_diff_pkg;

  localparam int unsigned WidthDef = 8;
  localparam int unsigned DigitDef = 2;

  typedef enum logic [1:0] {
    StIdle,
    StSub,
    StNeg,
    StDone
  } state_e;

  function automatic int unsigned calc_ndig(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  localparam int unsigned NdigDef = calc_ndig(WidthDef, DigitDef);

endpackage

// File: rtl/digit_add_slice.sv
// Combinational DIGIT-bit adder slice with carry in/out.
module digit_add_slice #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             c_o
);

  assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{DIGIT{1'b0}}, c_i};

endmodule

// File: rtl/abs_diff_seq_ctrl.sv
// Digit-serial |A-B|: subtract A-B one digit per cycle, then negate the
// partial result if the subtraction borrowed.
module abs_diff_seq_ctrl
  import abs_diff_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDef,
  parameter int unsigned DIGIT = DigitDef
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NDIG - 1);

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic [DIGIT-1:0] a_dig, b_dig, r_dig;
  logic [DIGIT-1:0] sl_a, sl_b, sl_sum;
  logic             sl_cout;
  logic             last_dig;

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    r_dig = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_dig = a_q[i*DIGIT +: DIGIT];
        b_dig = b_q[i*DIGIT +: DIGIT];
        r_dig = res_q[i*DIGIT +: DIGIT];
      end
    end
  end

  // SUB feeds A + ~B; NEG feeds ~R + 0, both with the running carry.
  assign sl_a     = (state_q == StNeg) ? ~r_dig : a_dig;
  assign sl_b     = (state_q == StNeg) ? '0 : ~b_dig;
  assign last_dig = (idx_q == LastIdx);

  digit_add_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .a_i  (sl_a),
    .b_i  (sl_b),
    .c_i  (carry_q),
    .sum_o(sl_sum),
    .c_o  (sl_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          res_d   = '0;
          idx_d   = '0;
          carry_d = 1'b1;
          state_d = StSub;
        end
      end
      StSub, StNeg: begin
        for (int unsigned i = 0; i < NDIG; i++) begin
          if (idx_q == IdxW'(i)) res_d[i*DIGIT +: DIGIT] = sl_sum;
        end
        carry_d = sl_cout;
        idx_d   = last_dig ? '0 : idx_q + IdxW'(1);
        if (last_dig) begin
          // No carry out of the subtraction means A < B: negate the result.
          if (state_q == StSub && !sl_cout) begin
            carry_d = 1'b1;
            state_d = StNeg;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = res_q;

endmodule

// File: tb/tb_abs_diff_seq_ctrl.sv
// Scoreboard bench for abs_diff_seq_ctrl: directed cases plus random traffic.
module tb_abs_diff_seq_ctrl;

  localparam int unsigned W    = 8;
  localparam int unsigned D    = 2;
  localparam int unsigned NDIG = W / D;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b, result;
  logic         busy, done;

  abs_diff_seq_ctrl #(
    .WIDTH(W),
    .DIGIT(D)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res;
  bit           have_last = 0;
  // Reference view of the one operation in flight: accepted at the edge
  // leaving cycle op_s, done visible in cycle op_s + op_lat.
  bit           op_act = 0;
  int           op_s   = 0;
  int           op_lat = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin : monitor
    bit busy_exp, done_exp;
    busy_exp = op_act && (cyc > op_s) && (cyc <= op_s + op_lat);
    done_exp = op_act && (cyc == op_s + op_lat);
    chk("busy", busy, busy_exp);
    chk("done", done, done_exp);
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        last_res  = exp_q.pop_front();
        have_last = 1;
        chk("result", result, last_res);
      end
    end else if (op_act && have_last && (cyc > op_s + op_lat)) begin
      chk("result_hold", result, last_res);
    end
  end

  task automatic wait_idle();
    while (op_act && cyc <= op_s + op_lat) begin
      @(negedge clk); #1;
    end
  endtask

  // Called just after a falling edge; waits until the reference is idle.
  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input bit keep);
    logic [W-1:0] e;
    wait_idle();
    start  = 1'b1;
    a      = xa;
    b      = xb;
    e      = (xa >= xb) ? xa - xb : xb - xa;
    op_act = 1;
    op_s   = cyc;
    op_lat = (xa >= xb) ? NDIG + 1 : 2 * NDIG + 1;
    exp_q.push_back(e);
    @(negedge clk); #1;
    if (!keep) start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] xa, xb;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    rst = 1'b0;

    issue(8'd200, 8'd55, 0);
    issue(8'd55, 8'd200, 0);
    issue(8'h80, 8'h80, 0);
    issue(8'd0, 8'd255, 0);

    // Start pulse with new operands during SUB cycle 2 must be ignored.
    issue(8'd10, 8'd3, 0);
    @(negedge clk); #1;
    start = 1'b1;
    a     = 8'd1;
    b     = 8'd1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (4) begin
      @(negedge clk); #1;
    end

    // Reset during NEG cycle 2 aborts the operation.
    issue(8'd3, 8'd9, 0);
    while (cyc < op_s + int'(NDIG) + 2) begin
      @(negedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    op_act = 0;
    exp_q.delete();
    @(negedge clk); #1;
    rst = 1'b0;
    issue(8'd9, 8'd3, 0);

    // Start held high: back-to-back operations.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) issue(8'd100 + 8'(i), 8'd20, 1);
      else            issue(8'd20, 8'd100 + 8'(i), 1);
    end
    start = 1'b0;
    wait_idle();

    // Random traffic with ignored start pulses and operand churn while busy.
    repeat (30) begin
      xa = W'($urandom);
      xb = ($urandom_range(3) == 0) ? xa : W'($urandom);
      issue(xa, xb, 0);
      while (cyc <= op_s + op_lat) begin
        start = ($urandom_range(2) == 0);
        a     = W'($urandom);
        b     = W'($urandom);
        @(negedge clk); #1;
      end
      start = 1'b0;
      repeat ($urandom_range(2)) begin
        @(negedge clk); #1;
      end
    end
    wait_idle();
    repeat (3) begin
      @(negedge clk); #1;
    end
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
